pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, 32, PC/address width in bits (>=8).
REQ-002 Parameter RESET_VECTOR, 0, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, 'h80, exception handler entry address.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC, FSM and RAS this cycle.
REQ-008 branch_en / branch_target  in  1 / WIDTH  conditional-branch redirect.
REQ-009 jump_en / jump_target  in  1 / WIDTH  unconditional redirect.
REQ-010 call  in  1  push pc_plus4 onto RAS and redirect to jump_target.
REQ-011 ret  in  1  pop RAS and redirect to popped address.
REQ-012 exc  in  1  external exception request.
REQ-013 eret  in  1  return from exception.
REQ-014 pc  out  WIDTH  current PC, registered.
REQ-015 pc_plus4  out  WIDTH  pc + 4, combinational, modulo 2^WIDTH.
REQ-016 epc  out  WIDTH  saved exception PC, registered.
REQ-017 in_handler  out  1  high in state HANDLER.
REQ-018 ras_empty / ras_full  out  1 / 1  RAS occupancy == 0 / == RAS_DEPTH.
REQ-019 ras_ovf / ras_unf  out  1 / 1  sticky overflow / underflow flags.

Function
REQ-020 Next-PC priority per cycle: exc or misalign > eret (HANDLER only) > ret > call > jump_en > branch_en > pc_plus4.
REQ-021 stall=1 with no exc: pc, epc, FSM, RAS, flags unchanged; exc overrides stall.
REQ-022 FSM states RUN, HANDLER; RUN->HANDLER on exc or misalign; HANDLER->RUN on eret; all else hold.
REQ-023 Exception taken in RUN: pc <= EXC_VECTOR, epc <= pc (faulting address).
REQ-024 Exception taken in HANDLER (nested): pc <= EXC_VECTOR, epc unchanged, stays HANDLER.
REQ-025 eret in HANDLER: pc <= epc next cycle; eret in RUN ignored (lower priorities apply).
REQ-026 misalign = selected redirect target (jump, branch, call, popped ret) with bits[1:0] != 0; redirect suppressed, treated as exception, RAS push/pop of that cycle cancelled.
REQ-027 call: push pc_plus4, pc <= jump_target, one cycle; RAS full: oldest entry overwritten (circular), occupancy stays RAS_DEPTH, ras_ovf set.
REQ-028 ret with RAS non-empty: pc <= top entry, occupancy -1; ret on empty: pc <= pc_plus4, ras_unf set, no pop.
REQ-029 call and ret asserted together: ret wins, call ignored (no push).
REQ-030 pc_plus4 wraps: pc = 2^WIDTH-4 gives pc_plus4 = 0.
REQ-031 Latency: any redirect visible on pc the cycle after it is sampled; no bubbles inserted.

Reset
REQ-032 rst low asynchronously: pc=RESET_VECTOR, epc=0, FSM=RUN, RAS occupancy 0, ras_ovf=ras_unf=0, in_handler=0.
REQ-033 Reset mid-operation discards pending redirects and all RAS contents; first edge after rst high samples inputs normally.
REQ-034 Sticky flags cleared only by reset.

Verification
REQ-035 Reset release, no controls, 3 clocks -> pc 0,4,8,12; stall=1 one cycle -> pc holds 12.
REQ-036 pc=0x10, call with jump_target=0x100 -> pc=0x100, RAS top=0x14; then ret -> pc=0x14, ras_empty=1.
REQ-037 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; 4 rets return last 4 pushes newest-first; 5th ret -> pc+4, ras_unf=1.
REQ-038 pc=0x40, exc with stall=1 -> pc=0x80, epc=0x40, in_handler=1; second exc -> epc still 0x40; eret -> pc=0x40, in_handler=0.
REQ-039 jump_en with jump_target=0x102 at pc=0x20 -> pc=0x80, epc=0x20; call+ret same cycle -> pop only, no push.
REQ-040 Force pc=0xFFFFFFFC (WIDTH=32) -> next pc=0; async rst low between edges -> pc=0 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with return-address stack and RUN/HANDLER exception FSM
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'('h80),
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);
  localparam int PW = $clog2(RAS_DEPTH);
  typedef enum logic {RUN, HANDLER} state_t;
  state_t state;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] tp;
  logic [PW:0] cnt;
  logic [WIDTH-1:0] top, tgt, pc_next;
  logic adv, eret_take, has_tgt, misalign, take_exc, ok, pop, push;
  assign pc_plus4   = pc + WIDTH'(4);
  assign top        = ras[tp - PW'(1)];
  assign ras_empty  = cnt == '0;
  assign ras_full   = cnt == (PW+1)'(RAS_DEPTH);
  assign in_handler = state == HANDLER;
  assign adv        = !stall || exc;
  assign eret_take  = eret && state == HANDLER;
  assign tgt        = ret ? top : (call || jump_en) ? jump_target : branch_target;
  assign has_tgt    = ret ? !ras_empty : (call || jump_en || branch_en);
  assign misalign   = !eret_take && has_tgt && tgt[1:0] != 2'b00;
  assign take_exc   = exc || misalign;
  assign ok         = adv && !take_exc && !eret_take;
  assign pop        = ok && ret && !ras_empty;
  assign push       = ok && !ret && call;
  assign pc_next    = take_exc ? EXC_VECTOR : eret_take ? epc :
                      ret ? (ras_empty ? pc_plus4 : top) :
                      (call || jump_en) ? jump_target : branch_en ? branch_target : pc_plus4;
  // RAS storage: circular buffer, a push on a full stack overwrites the oldest entry
  always_ff @(posedge clk)
    if (push) ras[tp] <= pc_plus4;
  // PC, EPC, FSM, stack pointers and sticky flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc      <= RESET_VECTOR;
      epc     <= '0;
      state   <= RUN;
      tp      <= '0;
      cnt     <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (adv) begin
      pc <= pc_next;
      if (take_exc && state == RUN) epc <= pc;
      state <= take_exc ? HANDLER : eret_take ? RUN : state;
      if (pop) begin
        tp  <= tp - PW'(1);
        cnt <= cnt - (PW+1)'(1);
      end
      if (push) begin
        tp  <= tp + PW'(1);
        cnt <= ras_full ? cnt : cnt + (PW+1)'(1);
      end
      if (push && ras_full) ras_ovf <= 1'b1;
      if (ok && ret && ras_empty) ras_unf <= 1'b1;
    end
endmodule
